gcd_multimode_engine: RTL and testbench

- Parametrised GCD engine.
- Computes gcd(a_in, b_in) of two unsigned WIDTH-bit operands captured in parallel on a start handshake.
- Supports two run-time-selectable algorithms: repeated subtraction and binary (Stein) shift/subtract.
- Replaces the fixed 16-bit serial-load GCD datapath/controller pair. Adds reset, a busy/done handshake, zero-operand handling and an iteration counter.

---
 rtl/gcd_multimode_engine.sv | 146 ++++++++++++++
 tb/tb_gcd_multimode_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_multimode_engine.sv
// GCD engine with run-time selectable repeated-subtraction or binary (Stein) algorithm.
// Operands are captured on an accepted start; result, step count and zero flag are held until the next start.
module gcd_multimode_engine #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic                 zero_err
);

  localparam int K_WIDTH = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Handshake: a request is taken when start=1 and busy=0 at a rising edge; busy stays
  // high until the cycle after the single-cycle done pulse, and requests seen while busy are dropped.
  logic [1:0]           state;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [K_WIDTH-1:0]   k_q;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 a_gt_b;
  logic                 a_eq_b;
  logic [WIDTH-1:0]     a_step;
  logic [WIDTH-1:0]     b_step;
  logic [K_WIDTH-1:0]   k_step;
  logic [CNT_WIDTH-1:0] cnt_step;
  logic [WIDTH-1:0]     final_value;

  assign a_gt_b      = (a_q > b_q);
  assign a_eq_b      = (a_q == b_q);
  assign cnt_step    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign final_value = mode_q ? (a_q << k_q) : a_q;

  // One reduction step; the larger operand is always the minuend so nothing underflows.
  always_comb begin
    a_step = a_q;
    b_step = b_q;
    k_step = k_q;
    if (!mode_q) begin
      if (a_gt_b) a_step = a_q - b_q;
      else        b_step = b_q - a_q;
    end else begin
      case ({a_q[0], b_q[0]})
        2'b00: begin
          a_step = a_q >> 1;
          b_step = b_q >> 1;
          k_step = k_q + K_WIDTH'(1);
        end
        2'b01:   a_step = a_q >> 1;
        2'b10:   b_step = b_q >> 1;
        default: begin
          if (a_gt_b) a_step = a_q - b_q;
          else        b_step = b_q - a_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      iter_count <= '0;
      zero_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q        <= a_in;
            b_q        <= b_in;
            mode_q     <= mode;
            k_q        <= '0;
            cnt_q      <= '0;
            iter_count <= '0;
            zero_err   <= 1'b0;
            busy       <= 1'b1;
            // A zero operand short-circuits straight to the done cycle.
            if (a_in == '0 && b_in == '0) begin
              result   <= '0;
              zero_err <= 1'b1;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else if (a_in == '0) begin
              result <= b_in;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else if (b_in == '0) begin
              result <= a_in;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              result <= '0;
              state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (a_eq_b) begin
            result     <= final_value;
            iter_count <= cnt_q;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else begin
            a_q   <= a_step;
            b_q   <= b_step;
            k_q   <= k_step;
            cnt_q <= cnt_step;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_multimode_engine.sv
// Self-checking bench for gcd_multimode_engine: directed scenarios plus a random sweep,
// expected results queued at stimulus time and popped when done fires.
module tb_gcd_multimode_engine;

  localparam int W = 16;

  logic         clock;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [15:0]  iter_count;
  logic         zero_err;

  logic         start_s;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic         busy_s;
  logic         done_s;
  logic [W-1:0] result_s;
  logic [3:0]   iter_s;
  logic         zero_s;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_iter_q[$];
  logic         exp_zero_q[$];

  gcd_multimode_engine #(.WIDTH(W), .CNT_WIDTH(16)) u_dut (
    .clock(clock), .rst_n(rst_n), .start(start), .mode(mode),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .iter_count(iter_count), .zero_err(zero_err)
  );

  gcd_multimode_engine #(.WIDTH(W), .CNT_WIDTH(4)) u_sat (
    .clock(clock), .rst_n(rst_n), .start(start_s), .mode(1'b0),
    .a_in(a_s), .b_in(b_s), .busy(busy_s), .done(done_s),
    .result(result_s), .iter_count(iter_s), .zero_err(zero_s)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Driver: one request, then wait for done. lat = cycle index of done (1 = cycle after accept edge).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        output int lat, output int busy_n, output bit ok);
    @(negedge clock);
    start = 1'b1; a_in = a; b_in = b; mode = m;
    @(negedge clock);
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); mode = 1'($urandom);
    lat = 1; busy_n = 0;
    while (!done && lat < 3000) begin
      if (busy) busy_n++;
      @(negedge clock);
      lat++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    start = 0; mode = 0; a_in = 0; b_in = 0; start_s = 0; a_s = 0; b_s = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d required 0", result); end
    checks++; if (iter_count !== '0) begin errors++; $display("FAIL reset_iter: got %0d required 0", iter_count); end
    checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL reset_zero_err: got %b required 0", zero_err); end
    checks++; if (done_s !== 1'b0 || result_s !== '0) begin
      errors++; $display("FAIL reset_sat: done=%b result=%0d required 0/0", done_s, result_s);
    end
    #19 rst_n = 1'b1;
  endtask

  task automatic test_subtraction();
    int lat, bn; bit ok;
    logic [W-1:0] e; logic [15:0] ei; logic ez;
    exp_q.push_back(13); exp_iter_q.push_back(6); exp_zero_q.push_back(1'b0);
    run_op(143, 78, 1'b0, lat, bn, ok);
    e = exp_q.pop_front(); ei = exp_iter_q.pop_front(); ez = exp_zero_q.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL sub_done: no done within %0d cycles", lat); end
    checks++; if (result !== e) begin errors++; $display("FAIL sub_result: got %0d required %0d", result, e); end
    checks++; if (iter_count !== ei) begin errors++; $display("FAIL sub_iter: got %0d required %0d", iter_count, ei); end
    checks++; if (zero_err !== ez) begin errors++; $display("FAIL sub_zero_err: got %b required %b", zero_err, ez); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL sub_latency: done in cycle %0d required 8", lat); end
    checks++; if (bn !== 7) begin errors++; $display("FAIL sub_busy_before_done: got %0d cycles required 7", bn); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sub_busy_at_done: got %b required 1", busy); end
    @(negedge clock);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL sub_pulse_width: done=%b busy=%b required 0/0", done, busy);
    end
    checks++; if (result !== 13) begin errors++; $display("FAIL sub_result_held: got %0d required 13", result); end
  endtask

  task automatic test_stein();
    int lat, bn; bit ok;
    logic [W-1:0] e; logic [15:0] ei; logic ez;
    exp_q.push_back(6); exp_iter_q.push_back(6); exp_zero_q.push_back(1'b0);
    run_op(48, 18, 1'b1, lat, bn, ok);
    e = exp_q.pop_front(); ei = exp_iter_q.pop_front(); ez = exp_zero_q.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL stein_done: no done within %0d cycles", lat); end
    checks++; if (result !== e) begin errors++; $display("FAIL stein_result: got %0d required %0d", result, e); end
    checks++; if (iter_count !== ei) begin errors++; $display("FAIL stein_iter: got %0d required %0d", iter_count, ei); end
    checks++; if (zero_err !== ez) begin errors++; $display("FAIL stein_zero_err: got %b required %b", zero_err, ez); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL stein_latency: done in cycle %0d required 8", lat); end
  endtask

  task automatic test_zero_operands();
    logic [W-1:0] ta[3] = '{16'd0, 16'd0, 16'd35};
    logic [W-1:0] tb[3] = '{16'd35, 16'd0, 16'd0};
    logic [W-1:0] tr[3] = '{16'd35, 16'd0, 16'd35};
    logic         tz[3] = '{1'b0, 1'b1, 1'b0};
    int lat, bn; bit ok;
    logic [W-1:0] e; logic [15:0] ei; logic ez;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(tr[i]); exp_iter_q.push_back(16'd0); exp_zero_q.push_back(tz[i]);
      run_op(ta[i], tb[i], 1'($urandom), lat, bn, ok);
      e = exp_q.pop_front(); ei = exp_iter_q.pop_front(); ez = exp_zero_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL zero_done[%0d]: no done within %0d cycles", i, lat); end
      checks++; if (result !== e) begin errors++; $display("FAIL zero_result[%0d]: got %0d required %0d", i, result, e); end
      checks++; if (iter_count !== ei) begin errors++; $display("FAIL zero_iter[%0d]: got %0d required %0d", i, iter_count, ei); end
      checks++; if (zero_err !== ez) begin errors++; $display("FAIL zero_flag[%0d]: got %b required %b", i, zero_err, ez); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency[%0d]: done in cycle %0d required 1", i, lat); end
    end
  endtask

  task automatic test_equal();
    int lat, bn; bit ok;
    logic [W-1:0] e; logic [15:0] ei;
    for (int m = 0; m < 2; m++) begin
      exp_q.push_back(9); exp_iter_q.push_back(16'd0);
      run_op(9, 9, 1'(m), lat, bn, ok);
      e = exp_q.pop_front(); ei = exp_iter_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL equal_done[m%0d]: no done within %0d cycles", m, lat); end
      checks++; if (result !== e) begin errors++; $display("FAIL equal_result[m%0d]: got %0d required %0d", m, result, e); end
      checks++; if (iter_count !== ei) begin errors++; $display("FAIL equal_iter[m%0d]: got %0d required %0d", m, iter_count, ei); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL equal_latency[m%0d]: done in cycle %0d required 2", m, lat); end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [W-1:0] e;
    exp_q.push_back(1);
    @(negedge clock);
    start_s = 1'b1; a_s = 1000; b_s = 1;
    @(negedge clock);
    start_s = 1'b0; a_s = W'($urandom); b_s = W'($urandom);
    lat = 1;
    while (!done_s && lat < 3000) begin
      @(negedge clock);
      lat++;
    end
    e = exp_q.pop_front();
    checks++; if (!done_s) begin errors++; $display("FAIL sat_done: no done within %0d cycles", lat); end
    checks++; if (result_s !== e) begin errors++; $display("FAIL sat_result: got %0d required %0d", result_s, e); end
    checks++; if (iter_s !== 4'd15) begin errors++; $display("FAIL sat_iter: got %0d required 15", iter_s); end
    checks++; if (lat !== 1001) begin errors++; $display("FAIL sat_latency: done in cycle %0d required 1001", lat); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn, pulses; bit ok;
    logic [W-1:0] e; logic [15:0] ei;
    @(negedge clock);
    start = 1'b1; a_in = 1000; b_in = 1; mode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || iter_count !== '0 || zero_err !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: busy=%b done=%b result=%0d iter=%0d zero=%b required all 0",
               busy, done, result, iter_count, zero_err);
    end
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(negedge clock);
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrun_no_done: %0d busy/done cycles required 0", pulses); end
    exp_q.push_back(7); exp_iter_q.push_back(16'd3);
    run_op(21, 14, 1'b1, lat, bn, ok);
    e = exp_q.pop_front(); ei = exp_iter_q.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL midrun_restart_done: no done within %0d cycles", lat); end
    checks++; if (result !== e) begin errors++; $display("FAIL midrun_restart_result: got %0d required %0d", result, e); end
    checks++; if (iter_count !== ei) begin errors++; $display("FAIL midrun_restart_iter: got %0d required %0d", iter_count, ei); end
  endtask

  task automatic test_start_while_busy();
    int lat, extra;
    logic [W-1:0] e;
    exp_q.push_back(13);
    @(negedge clock);
    start = 1'b1; a_in = 143; b_in = 78; mode = 1'b0;
    @(negedge clock);
    start = 1'b0; lat = 1;
    @(negedge clock); lat++;
    start = 1'b1; a_in = 5; b_in = 5; mode = 1'b1;
    @(negedge clock); lat++;
    start = 1'b0;
    while (!done && lat < 3000) begin
      @(negedge clock);
      lat++;
    end
    e = exp_q.pop_front();
    checks++; if (!done) begin errors++; $display("FAIL busy_start_done: no done within %0d cycles", lat); end
    checks++; if (result !== e) begin errors++; $display("FAIL busy_start_result: got %0d required %0d", result, e); end
    checks++; if (iter_count !== 16'd6) begin errors++; $display("FAIL busy_start_iter: got %0d required 6", iter_count); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL busy_start_latency: done in cycle %0d required 8", lat); end
    extra = 0;
    repeat (10) begin
      @(negedge clock);
      if (done || busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_queued: %0d busy/done cycles required 0", extra); end
  endtask

  task automatic test_back_to_back();
    int t, t1, t2;
    logic [W-1:0] e; logic [15:0] ei;
    exp_q.push_back(4); exp_iter_q.push_back(16'd2);
    exp_q.push_back(4); exp_iter_q.push_back(16'd2);
    @(negedge clock);
    start = 1'b1; a_in = 12; b_in = 8; mode = 1'b0;
    t = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && t < 200) begin
      @(negedge clock);
      t++;
      if (done) begin
        e = exp_q.pop_front(); ei = exp_iter_q.pop_front();
        checks++; if (result !== e) begin errors++; $display("FAIL b2b_result: got %0d required %0d", result, e); end
        checks++; if (iter_count !== ei) begin errors++; $display("FAIL b2b_iter: got %0d required %0d", iter_count, ei); end
        if (t1 < 0) t1 = t;
        else begin
          t2 = t;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++; if (t1 !== 4) begin errors++; $display("FAIL b2b_first_latency: cycle %0d required 4", t1); end
    checks++; if (t2 - t1 !== 5) begin errors++; $display("FAIL b2b_gap: got %0d cycles required 5", t2 - t1); end
  endtask

  task automatic test_random();
    int lat, bn; bit ok;
    logic [W-1:0] a, b, e;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom_range(1, 400));
      b = W'($urandom_range(1, 400));
      exp_q.push_back(gcd_ref(a, b));
      run_op(a, b, 1'($urandom_range(0, 1)), lat, bn, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || result !== e || zero_err !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] gcd(%0d,%0d): done=%b result=%0d zero=%b required result %0d zero 0",
                 i, a, b, ok, result, zero_err, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_subtraction();
    test_stein();
    test_zero_operands();
    test_equal();
    test_saturation();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
